// File: rtl/scoreboard_seg_display_pkg.sv
// Shared definitions for the scoreboard seven-segment display: FSM states,
// digit codes, glyph table and the double-dabble step used by the converter.
package scoreboard_seg_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_COMMIT = 2'd3
  } fsm_state_e;

  localparam logic [4:0] DIGIT_BLANK = 5'd16;
  localparam logic [4:0] DIGIT_NINE  = 5'd9;
  localparam logic [4:0] LAST_SHIFT  = 5'd15;

  // Active-high {g,f,e,d,c,b,a} patterns; entry 15 is glyph F, entry 0 is glyph 0.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // One double-dabble iteration on {5 BCD nibbles, 16-bit binary}.
  function automatic logic [35:0] dabble_step(input logic [35:0] value);
    logic [35:0] adj;
    adj = value;
    for (int i = 0; i < 5; i++) begin
      if (adj[16 + 4*i +: 4] >= 4'd5) begin
        adj[16 + 4*i +: 4] = adj[16 + 4*i +: 4] + 4'd3;
      end
    end
    return {adj[34:0], 1'b0};
  endfunction

endpackage

// File: rtl/scoreboard_seg_display_if.sv
// Scoreboard output-stage word and end-of-frame flag as seen by the display.
interface scoreboard_seg_display_if;

  logic [31:0] display_data;
  logic        scoreboard_eof;

  modport master (
    output display_data,
    output scoreboard_eof
  );

  modport slave (
    input display_data,
    input scoreboard_eof
  );

endinterface

// File: rtl/scoreboard_seg_display_seg7_encoder.sv
// Seven-segment encoder: 5-bit digit code (0-15 glyph, 16+ blank) to
// segment bits {g,f,e,d,c,b,a} with selectable polarity.
module seg7_encoder
  import scoreboard_seg_display_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [4:0] digit_code,
  output logic [6:0] segments
);

  logic [6:0] lit_s;

  // Glyph lookup followed by polarity adjustment.
  always_comb begin
    if (digit_code[4] == 1'b0) begin
      lit_s = GLYPH_TABLE[digit_code[3:0]];
    end else begin
      lit_s = 7'h00;
    end
    segments = SEG_ACTIVE_LOW ? ~lit_s : lit_s;
  end

endmodule

// File: rtl/scoreboard_seg_display.sv
// Drives eight seven-segment digits from the {user_id, score} word: id in hex,
// score in decimal via a sequential double-dabble conversion.
module scoreboard_seg_display
  import scoreboard_seg_display_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LEADING  = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  scoreboard_seg_display_if.slave        bus,
  output logic [6:0]                     hex7,
  output logic [6:0]                     hex6,
  output logic [6:0]                     hex5,
  output logic [6:0]                     hex4,
  output logic [6:0]                     hex3,
  output logic [6:0]                     hex2,
  output logic [6:0]                     hex1,
  output logic [6:0]                     hex0,
  output logic                           busy,
  output logic                           score_ovf
);

  fsm_state_e       state_r;
  fsm_state_e       state_s;
  logic             start_s;
  logic [31:0]      shadow_r;
  logic             pending_r;
  logic [35:0]      shift_r;
  logic [4:0]       count_r;
  logic [7:0][4:0]  digit_r;
  logic             score_ovf_r;
  logic             busy_r;

  logic [19:0]      bcd_s;
  logic             ovf_s;
  logic [3:0][4:0]  score_code_s;
  logic [7:0][4:0]  code_s;
  logic [7:0][6:0]  seg_s;

  // Next-state logic; a new conversion starts only from IDLE.
  always_comb begin
    state_s = state_r;
    start_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pending_r || (bus.display_data != shadow_r)) begin
          start_s = 1'b1;
          state_s = ST_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD:   state_s = ST_SHIFT;
      ST_SHIFT: begin
        if (count_r == LAST_SHIFT) begin
          state_s = ST_COMMIT;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      ST_COMMIT: state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // Score digit codes for commit: saturate above 9999, else leading-zero blanking.
  always_comb begin
    bcd_s = shift_r[35:16];
    ovf_s = (bcd_s[19:16] != 4'd0);
    if (ovf_s) begin
      score_code_s = {4{DIGIT_NINE}};
    end else begin
      score_code_s[3] = (BLANK_LEADING && (bcd_s[15:12] == 4'd0))
                        ? DIGIT_BLANK : {1'b0, bcd_s[15:12]};
      score_code_s[2] = (BLANK_LEADING && (bcd_s[15:8] == 8'd0))
                        ? DIGIT_BLANK : {1'b0, bcd_s[11:8]};
      score_code_s[1] = (BLANK_LEADING && (bcd_s[15:4] == 12'd0))
                        ? DIGIT_BLANK : {1'b0, bcd_s[7:4]};
      score_code_s[0] = {1'b0, bcd_s[3:0]};
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Conversion datapath, digit registers and status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_r    <= 32'd0;
      pending_r   <= 1'b1;
      shift_r     <= 36'd0;
      count_r     <= 5'd0;
      digit_r     <= {8{DIGIT_BLANK}};
      score_ovf_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      busy_r <= (state_s != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            shadow_r  <= bus.display_data;
            pending_r <= 1'b0;
          end
        end
        ST_LOAD: begin
          shift_r <= {20'd0, shadow_r[15:0]};
          count_r <= 5'd0;
        end
        ST_SHIFT: begin
          shift_r <= dabble_step(shift_r);
          count_r <= count_r + 5'd1;
        end
        ST_COMMIT: begin
          digit_r[7]  <= {1'b0, shadow_r[31:28]};
          digit_r[6]  <= {1'b0, shadow_r[27:24]};
          digit_r[5]  <= {1'b0, shadow_r[23:20]};
          digit_r[4]  <= {1'b0, shadow_r[19:16]};
          digit_r[3]  <= score_code_s[3];
          digit_r[2]  <= score_code_s[2];
          digit_r[1]  <= score_code_s[1];
          digit_r[0]  <= score_code_s[0];
          score_ovf_r <= ovf_s;
        end
        default: begin
          pending_r <= 1'b1;
        end
      endcase
    end
  end

  // End-of-frame overrides the displayed codes without touching the registers.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      code_s[i] = bus.scoreboard_eof ? DIGIT_BLANK : digit_r[i];
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_enc
    seg7_encoder #(
      .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
    ) u_enc (
      .digit_code(code_s[g]),
      .segments  (seg_s[g])
    );
  end

  assign hex7      = seg_s[7];
  assign hex6      = seg_s[6];
  assign hex5      = seg_s[5];
  assign hex4      = seg_s[4];
  assign hex3      = seg_s[3];
  assign hex2      = seg_s[2];
  assign hex1      = seg_s[1];
  assign hex0      = seg_s[0];
  assign busy      = busy_r;
  assign score_ovf = score_ovf_r;

endmodule

// File: tb/tb_scoreboard_seg_display.sv
// Self-checking bench for scoreboard_seg_display against an arithmetic
// decimal/hex display model.
module tb_scoreboard_seg_display;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0;
  logic       busy;
  logic       score_ovf;

  int checks = 0;
  int errors = 0;

  logic [6:0] hex_a   [8];
  logic [6:0] exp_hex [8];
  logic       exp_ovf;

  localparam logic [6:0] GLYPHS [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  scoreboard_seg_display_if bus ();

  scoreboard_seg_display #(
    .SEG_ACTIVE_LOW(1'b1),
    .BLANK_LEADING (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .hex7     (hex7),
    .hex6     (hex6),
    .hex5     (hex5),
    .hex4     (hex4),
    .hex3     (hex3),
    .hex2     (hex2),
    .hex1     (hex1),
    .hex0     (hex0),
    .busy     (busy),
    .score_ovf(score_ovf)
  );

  always #5 clk = ~clk;

  assign hex_a[0] = hex0;
  assign hex_a[1] = hex1;
  assign hex_a[2] = hex2;
  assign hex_a[3] = hex3;
  assign hex_a[4] = hex4;
  assign hex_a[5] = hex5;
  assign hex_a[6] = hex6;
  assign hex_a[7] = hex7;

  // Active-low segments for a digit value; negative means blank.
  function automatic logic [6:0] seg_al(input int v);
    if (v < 0) return 7'h7F;
    return ~GLYPHS[v];
  endfunction

  // Expected display for a data word, from decimal arithmetic on the score.
  task automatic compute_model(input logic [31:0] d);
    int id;
    int s;
    id = int'(d[31:16]);
    s  = int'(d[15:0]);
    for (int k = 0; k < 4; k++) exp_hex[4+k] = seg_al((id >> (4*k)) & 15);
    if (s > 9999) begin
      exp_ovf = 1'b1;
      for (int k = 0; k < 4; k++) exp_hex[k] = seg_al(9);
    end else begin
      exp_ovf    = 1'b0;
      exp_hex[3] = (s < 1000) ? seg_al(-1) : seg_al(s / 1000);
      exp_hex[2] = (s < 100)  ? seg_al(-1) : seg_al((s / 100) % 10);
      exp_hex[1] = (s < 10)   ? seg_al(-1) : seg_al((s / 10) % 10);
      exp_hex[0] = seg_al(s % 10);
    end
  endtask

  // Counts edges from the first edge after the data change until busy drops.
  task automatic run_conversion(output int n);
    @(posedge clk); #1;
    n = 1;
    while (busy === 1'b1 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.display_data   = 32'hBEEF_04D2;
    bus.scoreboard_eof = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++;
    if (score_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", score_ovf); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (hex_a[i] !== 7'h7F) begin
        errors++; $display("FAIL reset_hex%0d got %h exp 7f", i, hex_a[i]);
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    int n;
    logic [6:0] lit [8];
    lit = '{7'h19, 7'h30, 7'h24, 7'h79, 7'h0E, 7'h06, 7'h06, 7'h03};
    run_conversion(n);
    checks++;
    if (n != 19) begin errors++; $display("FAIL basic_latency got %0d exp 19", n); end
    checks++;
    if (score_ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf got %b exp 0", score_ovf); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (hex_a[i] !== lit[i]) begin
        errors++; $display("FAIL basic_hex%0d got %h exp %h", i, hex_a[i], lit[i]);
      end
    end
  endtask

  task automatic test_boundaries();
    int n;
    logic [15:0] scores [4];
    logic [31:0] d;
    scores = '{16'd0, 16'd7, 16'd10000, 16'd9999};
    for (int t = 0; t < 4; t++) begin
      d = {16'hBEEF, scores[t]};
      bus.display_data = d;
      compute_model(d);
      run_conversion(n);
      checks++;
      if (n != 19) begin errors++; $display("FAIL bound%0d_latency got %0d exp 19", t, n); end
      checks++;
      if (score_ovf !== exp_ovf) begin
        errors++; $display("FAIL bound%0d_ovf got %b exp %b", t, score_ovf, exp_ovf);
      end
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (hex_a[i] !== exp_hex[i]) begin
          errors++; $display("FAIL bound%0d_hex%0d got %h exp %h", t, i, hex_a[i], exp_hex[i]);
        end
      end
    end
  endtask

  task automatic test_change_during_busy();
    logic [31:0] d1;
    logic [31:0] d2;
    d1 = 32'h1357_04D2;
    d2 = 32'h1357_162E;
    bus.display_data = d1;
    for (int n = 1; n <= 38; n++) begin
      @(posedge clk); #1;
      if (n == 6) bus.display_data = d2;
      if (n == 19 || n == 37) begin
        compute_model(d1);
        for (int i = 0; i < 8; i++) begin
          checks++;
          if (hex_a[i] !== exp_hex[i]) begin
            errors++; $display("FAIL busychg_first_e%0d_hex%0d got %h exp %h", n - 1, i, hex_a[i], exp_hex[i]);
          end
        end
      end
      if (n == 19) begin
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busychg_e18_busy got %b exp 0", busy); end
      end
      if (n == 20) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busychg_restart_busy got %b exp 1", busy); end
      end
    end
    compute_model(d2);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busychg_e37_busy got %b exp 0", busy); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (hex_a[i] !== exp_hex[i]) begin
        errors++; $display("FAIL busychg_second_hex%0d got %h exp %h", i, hex_a[i], exp_hex[i]);
      end
    end
  endtask

  task automatic test_random();
    int n;
    int k;
    logic [31:0] prev;
    logic [31:0] v1;
    logic [31:0] vmid;
    logic [31:0] v2;
    prev = bus.display_data;
    for (int it = 0; it < 8; it++) begin
      v1   = {16'($urandom), 16'($urandom_range(0, 12000))};
      vmid = $urandom;
      v2   = {16'($urandom), 16'($urandom_range(0, 65535))};
      if (v1 == prev) v1 = v1 ^ 32'h1;
      if (v2 == v1) v2 = v2 ^ 32'h1;
      k = $urandom_range(2, 14);
      bus.display_data = v1;
      for (int e = 1; e <= 19; e++) begin
        @(posedge clk); #1;
        if (e == k) bus.display_data = vmid;
        if (e == k + 1) bus.display_data = v2;
      end
      compute_model(v1);
      checks++;
      if (score_ovf !== exp_ovf) begin
        errors++; $display("FAIL rand%0d_first_ovf got %b exp %b", it, score_ovf, exp_ovf);
      end
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (hex_a[i] !== exp_hex[i]) begin
          errors++; $display("FAIL rand%0d_first_hex%0d got %h exp %h", it, i, hex_a[i], exp_hex[i]);
        end
      end
      run_conversion(n);
      compute_model(v2);
      checks++;
      if (n != 19) begin errors++; $display("FAIL rand%0d_latency got %0d exp 19", it, n); end
      checks++;
      if (score_ovf !== exp_ovf) begin
        errors++; $display("FAIL rand%0d_second_ovf got %b exp %b", it, score_ovf, exp_ovf);
      end
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (hex_a[i] !== exp_hex[i]) begin
          errors++; $display("FAIL rand%0d_second_hex%0d got %h exp %h", it, i, hex_a[i], exp_hex[i]);
        end
      end
      prev = v2;
    end
  endtask

  task automatic test_eof();
    bus.display_data = 32'hA5C3_0309;
    for (int e = 0; e < 30; e++) begin
      @(posedge clk); #1;
      if (busy === 1'b0 && e > 0) break;
    end
    compute_model(32'hA5C3_0309);
    bus.scoreboard_eof = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL eof_busy c%0d got %b exp 0", c, busy); end
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (hex_a[i] !== 7'h7F) begin
          errors++; $display("FAIL eof_blank c%0d hex%0d got %h exp 7f", c, i, hex_a[i]);
        end
      end
      @(posedge clk); #1;
    end
    bus.scoreboard_eof = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (hex_a[i] !== exp_hex[i]) begin
        errors++; $display("FAIL eof_restore_hex%0d got %h exp %h", i, hex_a[i], exp_hex[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bus.display_data = 32'h0C0D_2468;
    for (int n = 1; n <= 11; n++) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (hex_a[i] !== 7'h7F) begin
        errors++; $display("FAIL rstmid_blank_hex%0d got %h exp 7f", i, hex_a[i]);
      end
    end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int n = 1; n <= 19; n++) begin
      @(posedge clk); #1;
      if (n == 18) begin
        checks++;
        if (busy !== 1'b1 || hex0 !== 7'h7F) begin
          errors++; $display("FAIL rstmid_e17 got busy %b hex0 %h exp busy 1 hex0 7f", busy, hex0);
        end
      end
    end
    compute_model(32'h0C0D_2468);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_done_busy got %b exp 0", busy); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (hex_a[i] !== exp_hex[i]) begin
        errors++; $display("FAIL rstmid_hex%0d got %h exp %h", i, hex_a[i], exp_hex[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_change_during_busy();
    test_random();
    test_eof();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scoreboard_seg_display.md
Name: scoreboard_seg_display

Overview:
- Downstream consumer of the scoreboard output stage.
- Takes the 32-bit {user_id, score} word and drives eight seven-segment digits:
  - user id as 4 hex digits on hex7..hex4;
  - score as 4 decimal digits on hex3..hex0.
- Score binary-to-BCD conversion is sequential (double-dabble, one bit per clock). The displayed value is held stable until a conversion completes.
- Blanks all digits when the scoreboard signals end-of-frame.

Parameters:
- SEG_ACTIVE_LOW, 1, 1 = segment lit when driven 0 (board default); 0 = active-high.
- BLANK_LEADING, 1, 1 = blank leading zeros of the score (units digit always shown).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- display_data  in  32  [31:16] user_id, [15:0] score, binary.
- scoreboard_eof  in  1  1 = blank all eight digits (combinational override, no state change).
- hex7..hex0  out  7 each  segment bits {g,f,e,d,c,b,a}; hex7 = id MS nibble, hex0 = score units.
- busy  out  1  conversion in progress.
- score_ovf  out  1  last committed score > 9999.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM to IDLE; busy=0; score_ovf=0.
  - All digit registers = blank, so hex outputs = all segments off (7'h7F when active-low).
  - shadow register = 0; pending = 1.
- FSM states: IDLE, LOAD, SHIFT, COMMIT.
  - IDLE: if pending=1 or display_data != shadow, go to LOAD and, on the same edge, capture shadow <= display_data and clear pending. Otherwise stay.
  - LOAD: shift reg <= {20'b0, shadow[15:0]}; iteration count = 0; go to SHIFT.
  - SHIFT: each cycle, first add 3 to every one of the 5 BCD nibbles that is >= 5, then shift the whole register left by 1; count++.
    - After the 16th shift, go to COMMIT.
    - count is 5 bits; no wrap occurs.
  - COMMIT:
    - If the ten-thousands nibble != 0: score digits = 9,9,9,9 and score_ovf = 1. Otherwise the 4 low BCD nibbles and score_ovf = 0.
    - id digits = shadow[31:16] nibbles.
    - Go to IDLE.
- busy = 1 in LOAD, SHIFT and COMMIT; 0 in IDLE.
- Latency: data changes before edge E0. Then E0: IDLE→LOAD; E1: →SHIFT; E2..E17: 16 shifts (E17 also →COMMIT); E18: digit registers update, busy falls. Input change to new display = 18 edges after E0.
- Change during busy:
  - The current conversion finishes on the captured value.
  - pending is not set; the IDLE compare detects the difference and restarts at the next edge.
  - Changes that are overwritten before IDLE are dropped. Only the value present in IDLE is converted.
- Leading blank (BLANK_LEADING=1):
  - thousands blank if 0;
  - hundreds blank if thousands and hundreds are both 0;
  - tens blank likewise;
  - units never blank;
  - not applied when score_ovf=1.
- Id digits are never blanked.
- Digit registers hold a 5-bit code: 0-15 = hex glyph, 16 = blank. Segment encoding is combinational from the register.
- Segment patterns, active-high: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71, blank=00. Inverted when SEG_ACTIVE_LOW=1.
- scoreboard_eof=1 forces all hex to blank combinationally. The FSM and digit registers are unaffected; the display restores the same cycle eof falls.
- Reset mid-conversion aborts it. Outputs stay blank until the automatic post-reset conversion commits, 18 edges after rst rises.

Decomposition:
- Shared include (scoreboard_defs):
  - FSM state encodings;
  - DIGIT_BLANK=5'd16;
  - 16-entry glyph constant table.
- Sub-module seg7_encoder: 5-bit digit code + polarity → 7-bit segments.
  - Pure combinational; instantiated 8 times.

Test Plan:
- Reset released, display_data=32'hBEEF_04D2 → busy high 18 edges.
  - Then hex7..hex4 = 03,06,06,0E (B,E,E,F active-low).
  - hex3..hex0 = 79,24,30,19 (1234).
  - score_ovf=0.
- Score 0x0000 → hex3..hex1 = 7F (blank), hex0 = 40 ("0").
- Score 0x0007 → hex3..hex1 blank, hex0 = 78.
- Score 10000 (0x2710) → hex3..hex0 all 10 ("9"), score_ovf=1. Then score 9999 → same digits, score_ovf=0.
- Score 1234 applied, then 5678 applied at E5 during busy → 1234 commits at E18; restart at E19; 5678 (hex3..0 = 12,02,78,00) commits at E37.
- scoreboard_eof pulsed high for 3 cycles while idle → all hex = 7F during pulse, prior digits back on the same cycle eof falls, busy stays 0.
- rst asserted at E10 of a conversion → immediate blank outputs, busy=0; after release, current display_data commits 18 edges later.
